// File: rtl/top_i2c_interface_if.sv
// Serial link bundle: bit clock and data towards the receiver, parallel byte back.
interface top_i2c_interface_if;
  logic       clk;
  logic       data;
  logic [7:0] interface_output_data;

  modport master (output clk, output data, input interface_output_data);
  modport slave  (input clk, input data, output interface_output_data);
endinterface

// File: rtl/top_i2c_interface.sv
// Oversampling receiver for 11-bit frames (ctrl[1:0], data[7:0], parity) on a sampled clk/data pair.
// Holds the last frame whose control field and parity both check out.
module top_i2c_interface #(
  parameter logic [1:0]  CTRL_PATTERN = 2'b01,
  parameter bit          ODD_PARITY   = 1'b0,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 f_clk,
  input  logic                 rst_n,
  top_i2c_interface_if.slave   bus
);

  localparam int unsigned CNT_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BCNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CTRL   = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_clk_sync;
  logic [SYNC_STAGES-1:0]  r_data_sync;
  logic                    r_clk_d;
  logic [CNT_W-1:0]        r_idle_cnt;
  logic [1:0]              r_ctrl;
  logic [DATA_W-1:0]       r_shift;
  logic                    r_par;
  logic [BCNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]       r_out;

  logic w_strobe;
  logic w_bit;
  logic w_timeout;
  logic w_adv;
  logic w_frame_ok;
  logic w_c1_we;
  logic w_c0_we;
  logic w_cnt_clr;
  logic w_shift_we;
  logic w_par_we;
  logic w_load;

  // Bring the asynchronous serial pins into the f_clk domain
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '0;
      r_data_sync <= '0;
      r_clk_d     <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.data};
      r_clk_d     <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_strobe = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
  assign w_bit    = r_data_sync[SYNC_STAGES-1];

  // Saturating gap counter; cleared by every bit strobe
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_strobe) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != CNT_W'(IDLE_TIMEOUT)) begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end

  assign w_timeout  = (r_idle_cnt == CNT_W'(IDLE_TIMEOUT)) && (r_state != S_IDLE);
  assign w_adv      = w_strobe & ~w_timeout;
  assign w_frame_ok = (r_ctrl == CTRL_PATTERN) && ((^{r_shift, r_par}) == ODD_PARITY);

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_strobe) w_state_nxt = S_CTRL;
        S_CTRL:   if (w_strobe) w_state_nxt = S_DATA;
        S_DATA:   if (w_strobe && (r_bit_cnt == BCNT_W'(DATA_W - 1))) w_state_nxt = S_PARITY;
        S_PARITY: if (w_strobe) w_state_nxt = S_CHECK;
        S_CHECK:  w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_c1_we    = 1'b0;
    w_c0_we    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_shift_we = 1'b0;
    w_par_we   = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE:   w_c1_we    = w_adv;
      S_CTRL: begin
        w_c0_we   = w_adv;
        w_cnt_clr = w_adv;
      end
      S_DATA:   w_shift_we = w_adv;
      S_PARITY: w_par_we   = w_adv;
      S_CHECK:  w_load     = w_frame_ok;
      default:  w_load     = 1'b0;
    endcase
  end

  // Frame capture and accepted-byte register
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
      r_out     <= '0;
    end else begin
      if (w_c1_we)   r_ctrl[1] <= w_bit;
      if (w_c0_we)   r_ctrl[0] <= w_bit;
      if (w_cnt_clr) r_bit_cnt <= '0;
      if (w_shift_we) begin
        r_shift   <= {r_shift[DATA_W-2:0], w_bit};
        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
      end
      if (w_par_we)  r_par <= w_bit;
      if (w_load)    r_out <= r_shift;
    end
  end

  assign bus.interface_output_data = r_out;

endmodule

// File: tb/tb_top_i2c_interface.sv
// Directed bench for top_i2c_interface: valid, corrupted, truncated and reset-interrupted frames.
module tb_top_i2c_interface;

  logic f_clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;

  top_i2c_interface_if bus ();

  top_i2c_interface dut (
    .f_clk (f_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial f_clk = 1'b0;
  always #1 f_clk = ~f_clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One serial bit: data set while clk low, clk period 20
  task automatic send_bit(input logic b);
    bus.data = b;
    #5 bus.clk = 1'b1;
    #10 bus.clk = 1'b0;
    #5;
  endtask

  task automatic send_frame(input logic [1:0] ctrl, input logic [7:0] d, input logic p);
    logic [10:0] bits;
    bits = {ctrl, d, p};
    for (int i = 10; i >= 0; i--) send_bit(bits[i]);
  endtask

  // Frame with the control field set but the old byte checked just before the parity strobe
  task automatic send_frame_chk(input logic [1:0] ctrl, input logic [7:0] d, input logic p,
                                input logic [7:0] old_val, input string tag);
    logic [10:0] bits;
    bits = {ctrl, d, p};
    for (int i = 10; i >= 1; i--) send_bit(bits[i]);
    check_eq(tag, bus.interface_output_data, old_val);
    send_bit(bits[0]);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge f_clk);
    @(negedge f_clk);
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    bus.clk  = 1'b0;
    bus.data = 1'b0;
    #7 rst_n = 1'b1;

    // 1: reset state holds with no stimulus
    @(negedge f_clk);
    check_eq("reset", bus.interface_output_data, 8'h00);
    idle_gap(200);
    check_eq("reset_hold", bus.interface_output_data, 8'h00);

    // 2: valid frames, even parity
    send_frame_chk(2'b01, 8'h23, 1'b1, 8'h00, "pre_par_23");
    idle_gap(200);
    check_eq("valid_23", bus.interface_output_data, 8'h23);
    send_frame_chk(2'b01, 8'h43, 1'b1, 8'h23, "pre_par_43");
    idle_gap(200);
    check_eq("valid_43", bus.interface_output_data, 8'h43);
    send_frame(2'b01, 8'h5A, 1'b0);
    idle_gap(200);
    check_eq("valid_5A", bus.interface_output_data, 8'h5A);

    // 3: data bit flipped, parity still computed for 8'h42
    send_frame(2'b01, 8'h42, 1'b0);
    idle_gap(200);
    check_eq("valid_42", bus.interface_output_data, 8'h42);
    send_frame(2'b01, 8'h43, 1'b0);
    idle_gap(200);
    check_eq("bad_data_bit", bus.interface_output_data, 8'h42);

    // 4: parity inverted
    send_frame(2'b01, 8'h24, 1'b1);
    idle_gap(200);
    check_eq("bad_parity", bus.interface_output_data, 8'h42);

    // 5: control field errors
    send_frame(2'b11, 8'h42, 1'b0);
    idle_gap(200);
    check_eq("bad_ctrl_11", bus.interface_output_data, 8'h42);
    send_frame(2'b00, 8'h53, 1'b0);
    idle_gap(200);
    check_eq("bad_ctrl_00", bus.interface_output_data, 8'h42);

    // Boundary bytes, back-to-back with no gap
    send_frame(2'b01, 8'h00, 1'b0);
    check_eq("b2b_00", bus.interface_output_data, 8'h00);
    send_frame(2'b01, 8'hFF, 1'b0);
    check_eq("b2b_FF", bus.interface_output_data, 8'hFF);
    idle_gap(200);

    // 6: truncated frame aborted by the idle timeout
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle_gap(100);
    check_eq("timeout_hold", bus.interface_output_data, 8'hFF);
    send_frame(2'b01, 8'h3C, 1'b0);
    idle_gap(200);
    check_eq("after_timeout_3C", bus.interface_output_data, 8'h3C);

    // Reset mid-frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #3 rst_n = 1'b0;
    #1 check_eq("mid_reset", bus.interface_output_data, 8'h00);
    #6 rst_n = 1'b1;
    idle_gap(20);
    check_eq("post_reset_hold", bus.interface_output_data, 8'h00);
    send_frame(2'b01, 8'h2C, 1'b1);
    idle_gap(200);
    check_eq("after_reset_2C", bus.interface_output_data, 8'h2C);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", n_bad + 1);
    $fatal(1);
  end

endmodule
